// File: rtl/ifetch_prefetch_if.sv
// ifetch_prefetch_if
// Groups the instruction-ROM read port and the decode-side valid/ready
// handshake of the prefetching fetch unit.
//   imem_en / imem_addr   fetch -> ROM, read strobe and word address
//   imem_rdata            ROM -> fetch, data one cycle after imem_en
//   out_valid / out_ready head-of-queue handshake towards decode
//   out_instr / out_pc_plus_4  head instruction and its address + 4
// modport master: the fetch unit; modport slave: ROM + decode side.
interface ifetch_prefetch_if #(
   parameter int ADDR_W = 32,
   parameter int ROM_AW = 14
);
   logic              imem_en;
   logic [ROM_AW-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_pc_plus_4;

   modport master (
      output imem_en, imem_addr, out_valid, out_instr, out_pc_plus_4,
      input  imem_rdata, out_ready
   );

   modport slave (
      input  imem_en, imem_addr, out_valid, out_instr, out_pc_plus_4,
      output imem_rdata, out_ready
   );
endinterface

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
// Fetch unit with a DEPTH-entry prefetch queue in front of a synchronous
// instruction ROM (one-cycle read latency). Execute-stage redirects (jr,
// j/jal, beq, bne) are resolved here; a taken redirect flushes the queue
// and restarts fetch at the target.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   bus (master)        ROM read port and decode handshake
//   redir_valid         execute-stage control below is valid this cycle
//   Branch, nBranch, Jmp, Jal, Jrn, Zero   execute-stage control
//   redir_pc_plus_4     PC+4 of the redirecting instruction
//   Add_result          branch target
//   Read_data_1         jr target
//   jidx                jump index field
// Optional feature macro IFETCH_JAL_LINK_EN adds link_valid / link_addr,
// a one-cycle pulse carrying the return address of a taken jal.
module ifetch_prefetch #(
   parameter int              ADDR_W   = 32,
   parameter int              ROM_AW   = 14,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   ifetch_prefetch_if.master bus,
   input  logic              redir_valid,
   input  logic              Branch,
   input  logic              nBranch,
   input  logic              Jmp,
   input  logic              Jal,
   input  logic              Jrn,
   input  logic              Zero,
   input  logic [ADDR_W-1:0] redir_pc_plus_4,
   input  logic [ADDR_W-1:0] Add_result,
   input  logic [ADDR_W-1:0] Read_data_1,
   input  logic [25:0]       jidx
`ifdef IFETCH_JAL_LINK_EN
   ,
   output logic              link_valid,
   output logic [ADDR_W-1:0] link_addr
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

   logic [31:0]       r_q_instr [DEPTH];
   logic [ADDR_W-1:0] r_q_pc4   [DEPTH];
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_count;
   logic              r_inf;
   logic [ADDR_W-1:0] r_fpc;
   logic [ADDR_W-1:0] r_tag;

   logic              w_taken;
   logic [ADDR_W-1:0] w_target;
   logic [CW:0]       w_occ;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic              w_unused_bits;

   assign w_taken = redir_valid & (Jrn | Jmp | Jal | (Branch & Zero) | (nBranch & ~Zero));

   // Jrn outranks Jmp/Jal, which outrank the conditional branches.
   always_comb begin
      w_target = Add_result;
      if (Jrn)
         w_target = Read_data_1;
      else if (Jmp | Jal)
         w_target = {redir_pc_plus_4[ADDR_W-1:28], jidx, 2'b00};
      w_target[1:0] = 2'b00;
   end

   // The in-flight word counts against capacity so its push can never overflow.
   assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inf};
   assign w_issue = reset & ~w_taken & (w_occ < DEPTH_C);

   // A response landing in the redirect cycle is dropped by the flush itself,
   // and no fetch is issued that cycle, so nothing stale can arrive later.
   assign w_push  = r_inf & ~w_taken;
   assign w_pop   = bus.out_valid & bus.out_ready & ~w_taken;

   assign bus.imem_en       = w_issue;
   assign bus.imem_addr     = r_fpc[ROM_AW+1:2];
   assign bus.out_valid     = (r_count != '0);
   assign bus.out_instr     = r_q_instr[r_rd_ptr];
   assign bus.out_pc_plus_4 = r_q_pc4[r_rd_ptr];

   assign w_unused_bits = ^redir_pc_plus_4[27:0];

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_fpc    <= {RESET_PC[ADDR_W-1:2], 2'b00};
         r_tag    <= '0;
         r_count  <= '0;
         r_inf    <= 1'b0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_instr[i] <= '0;
            r_q_pc4[i]   <= '0;
         end
      end else begin
         r_inf <= w_issue;
         if (w_issue) begin
            r_fpc <= r_fpc + ADDR_W'(4);
            r_tag <= r_fpc + ADDR_W'(4);
         end
         if (w_taken) begin
            r_fpc    <= w_target;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push) begin
               r_q_instr[r_wr_ptr] <= bus.imem_rdata;
               r_q_pc4[r_wr_ptr]   <= r_tag;
               r_wr_ptr            <= r_wr_ptr + PW'(1);
            end
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

`ifdef IFETCH_JAL_LINK_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else begin
         link_valid <= w_taken & Jal;
         if (w_taken & Jal)
            link_addr <= redir_pc_plus_4;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch
// Directed bench for ifetch_prefetch (DEPTH=4, RESET_PC=0). ROM word i
// holds the value i. Expected deliveries are queued as stimulus is issued;
// a monitor pops and compares on every accepted handshake.
module tb_ifetch_prefetch;
   localparam int ADDR_W = 32;
   localparam int ROM_AW = 14;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   localparam int K_BR  = 0;
   localparam int K_JRJ = 1;
   localparam int K_JMP = 2;
   localparam int K_JAL = 3;
   localparam int K_NBR = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        redir_valid, Branch, nBranch, Jmp, Jal, Jrn, Zero;
   logic [31:0] redir_pc_plus_4, Add_result, Read_data_1;
   logic [25:0] jidx;
   logic        link_valid;
   logic [31:0] link_addr;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   ifetch_prefetch_if #(.ADDR_W(ADDR_W), .ROM_AW(ROM_AW)) bus ();

   ifetch_prefetch #(.ADDR_W(ADDR_W), .ROM_AW(ROM_AW), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clock           (clock),
      .reset           (reset),
      .bus             (bus),
      .redir_valid     (redir_valid),
      .Branch          (Branch),
      .nBranch         (nBranch),
      .Jmp             (Jmp),
      .Jal             (Jal),
      .Jrn             (Jrn),
      .Zero            (Zero),
      .redir_pc_plus_4 (redir_pc_plus_4),
      .Add_result      (Add_result),
      .Read_data_1     (Read_data_1),
      .jidx            (jidx)
`ifdef IFETCH_JAL_LINK_EN
      ,
      .link_valid      (link_valid),
      .link_addr       (link_addr)
`endif
   );

`ifndef IFETCH_JAL_LINK_EN
   assign link_valid = 1'b0;
   assign link_addr  = '0;
`endif

   always #5 clock = ~clock;

   // ROM model: word i holds i, one-cycle latency.
   always @(posedge clock)
      if (bus.imem_en)
         bus.imem_rdata <= {18'd0, bus.imem_addr};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic tb_taken();
      return redir_valid & (Jrn | Jmp | Jal | (Branch & Zero) | (nBranch & ~Zero));
   endfunction

   task automatic clear_redir();
      redir_valid = 0; Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jrn = 0; Zero = 0;
   endtask

   task automatic push_exp(input logic [31:0] w0, input logic [31:0] p0, input int n);
      for (int k = 0; k < n; k++) begin
         exp_t e;
         e.instr = w0 + k;
         e.pc4   = p0 + 4 * k;
         sb.push_back(e);
      end
   endtask

   // Monitor: handshake sampled mid-cycle, counted only if it will really pop.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (reset && bus.out_valid && bus.out_ready && !tb_taken()) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_delivery", {32'h0, bus.out_pc_plus_4}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_instr", {32'h0, bus.out_instr}, {32'h0, e.instr});
               check("sb_pc4", {32'h0, bus.out_pc_plus_4}, {32'h0, e.pc4});
            end
         end
      end
   end

   // Taken redirect at the current negedge, then stream n words from the target.
   task automatic redir_stream(input int kind, input logic [31:0] w0, input logic [31:0] p0,
                               input int n, input bit nt);
      push_exp(w0, p0, n);
      clear_redir();
      redir_valid = 1;
      bus.out_ready = 1;   // a pop in the redirect cycle must be ignored
      case (kind)
         K_BR:  begin Branch = 1; Zero = 1; Add_result = 32'h40; end
         K_JRJ: begin Jrn = 1; Jmp = 1; Read_data_1 = 32'h103; jidx = 26'h155; redir_pc_plus_4 = 32'h0; end
         K_JMP: begin Jmp = 1; jidx = 26'h10; redir_pc_plus_4 = 32'h3000_002C; end
         K_JAL: begin Jal = 1; jidx = 26'h20; redir_pc_plus_4 = 32'h0000_002C; end
         default: begin nBranch = 1; Zero = 0; Add_result = 32'h203; end
      endcase
      #1;
      check("redir_no_issue", {63'h0, bus.imem_en}, 64'h0);
      @(negedge clock);
      clear_redir();
      check("flush_valid_e1", {63'h0, bus.out_valid}, 64'h0);
      check("link_pulse", {63'h0, link_valid},
`ifdef IFETCH_JAL_LINK_EN
            (kind == K_JAL) ? 64'h1 : 64'h0);
`else
            64'h0);
`endif
      if (kind == K_JAL)
         check("link_addr", {32'h0, link_addr},
`ifdef IFETCH_JAL_LINK_EN
               64'h2C);
`else
               64'h0);
`endif
      @(negedge clock);
      check("flush_valid_e2", {63'h0, bus.out_valid}, 64'h0);
      check("link_one_cycle", {63'h0, link_valid}, 64'h0);
      @(negedge clock);
      check("target_valid", {63'h0, bus.out_valid}, 64'h1);
      check("target_pc4", {32'h0, bus.out_pc_plus_4}, {32'h0, p0});
      check("target_instr", {32'h0, bus.out_instr}, {32'h0, w0});
      for (int j = 1; j < n; j++) begin
         @(negedge clock);
         clear_redir();
         check("stream_valid", {63'h0, bus.out_valid}, 64'h1);
         if (nt && j == 2) begin
            redir_valid = 1; Branch = 1; Zero = 0; Add_result = 32'h800;
         end
      end
      @(negedge clock);
      clear_redir();
      bus.out_ready = 0;
   endtask

   initial begin
      reset = 0;
      bus.out_ready = 0;
      clear_redir();
      redir_pc_plus_4 = 0; Add_result = 0; Read_data_1 = 0; jidx = 0;
      repeat (3) @(negedge clock);
      check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check("rst_imem_en", {63'h0, bus.imem_en}, 64'h0);
      check("rst_out_instr", {32'h0, bus.out_instr}, 64'h0);
      check("rst_out_pc4", {32'h0, bus.out_pc_plus_4}, 64'h0);
      check("rst_link_valid", {63'h0, link_valid}, 64'h0);

      // Reset release and steady stream of words 0..7
      reset = 1;
      bus.out_ready = 1;
      push_exp(32'd0, 32'd4, 8);
      @(negedge clock);
      check("fill_valid_r1", {63'h0, bus.out_valid}, 64'h0);
      check("fill_imem_en", {63'h0, bus.imem_en}, 64'h1);
      @(negedge clock);
      check("first_valid_r2", {63'h0, bus.out_valid}, 64'h1);
      check("first_instr", {32'h0, bus.out_instr}, 64'h0);
      check("first_pc4", {32'h0, bus.out_pc_plus_4}, 64'h4);
      for (int j = 1; j < 8; j++) begin
         @(negedge clock);
         check("steady_valid", {63'h0, bus.out_valid}, 64'h1);
      end
      @(negedge clock);
      bus.out_ready = 0;

      // Stall: words 8..11 buffered, fetch PC parked at word 12
      repeat (5) @(negedge clock);
      check("full_imem_en_a", {63'h0, bus.imem_en}, 64'h0);
      check("full_addr_a", {50'h0, bus.imem_addr}, 64'd12);
      repeat (5) @(negedge clock);
      check("full_imem_en_b", {63'h0, bus.imem_en}, 64'h0);
      check("full_addr_b", {50'h0, bus.imem_addr}, 64'd12);
      check("full_head", {32'h0, bus.out_instr}, 64'd8);

      // Pop one so word 12 goes in flight, then branch taken over it
      bus.out_ready = 1;
      push_exp(32'd8, 32'd36, 1);
      @(negedge clock);
      bus.out_ready = 0;
      @(negedge clock);
      check("inflight_en_low", {63'h0, bus.imem_en}, 64'h0);
      redir_stream(K_BR, 32'h10, 32'h44, 8, 1'b1);

      redir_stream(K_JRJ, 32'h40, 32'h104, 3, 1'b0);
      redir_stream(K_JMP, 32'h10, 32'h3000_0044, 3, 1'b0);
      redir_stream(K_JAL, 32'h20, 32'h84, 3, 1'b0);
      redir_stream(K_NBR, 32'h80, 32'h204, 4, 1'b0);

      // Reset mid-stream
      @(negedge clock);
      check("pre_reset_valid", {63'h0, bus.out_valid}, 64'h1);
      reset = 0;
      #1;
      check("reset_imem_en_now", {63'h0, bus.imem_en}, 64'h0);
      @(negedge clock);
      check("reset_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check("reset_imem_en", {63'h0, bus.imem_en}, 64'h0);
      check("reset_out_instr", {32'h0, bus.out_instr}, 64'h0);
      reset = 1;
      bus.out_ready = 1;
      push_exp(32'd0, 32'd4, 4);
      @(negedge clock);
      check("restart_valid_r1", {63'h0, bus.out_valid}, 64'h0);
      @(negedge clock);
      check("restart_valid_r2", {63'h0, bus.out_valid}, 64'h1);
      check("restart_pc4", {32'h0, bus.out_pc_plus_4}, 64'h4);
      for (int j = 1; j < 4; j++) begin
         @(negedge clock);
         check("restart_stream", {63'h0, bus.out_valid}, 64'h1);
      end
      @(negedge clock);
      bus.out_ready = 0;
      repeat (3) @(negedge clock);
      check("sb_drained", 64'(sb.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
      $fatal(1);
   end
endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Parametrised successor to the Minisys single-cycle fetch unit. It holds the fetch PC, drives a synchronous instruction ROM with one-cycle read latency, and buffers fetched words in a DEPTH-entry prefetch queue. Decode drains the queue through a valid/ready handshake. Branch, jump, jal and jr redirects from the execute stage are resolved internally and flush the queue.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits (≥ 28 + ROM_AW relevance not required; ≥ ROM_AW+2)
- ROM_AW, 14, ROM word-address width
- DEPTH, 4, prefetch queue entries; power of two, ≥ 2
- RESET_PC, 0, fetch address after reset; bits [1:0] ignored

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low reset
- imem_en  out  1  ROM read strobe
- imem_addr  out  ROM_AW  ROM word address = fpc[ROM_AW+1:2]
- imem_rdata  in  32  ROM data, valid the cycle after imem_en
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc_plus_4  out  ADDR_W  head instruction address + 4
- redir_valid  in  1  execute-stage control below is valid this cycle
- Branch, nBranch, Jmp, Jal, Jrn, Zero  in  1 each  execute-stage control, Minisys semantics
- redir_pc_plus_4  in  ADDR_W  PC+4 of the redirecting instruction
- Add_result  in  ADDR_W  branch target
- Read_data_1  in  ADDR_W  jr target
- jidx  in  26  jump index field

## Operation
- State: fetch PC fpc; queue (instr, pc+4) of DEPTH entries with count; in-flight flag inf; kill flag.
- Fetch issue: imem_en = reset high and (count + inf + push-pending) < DEPTH and no taken redirect this cycle. On issue, fpc <= fpc+4 (mod 2^ADDR_W), inf <= 1, and the pc+4 tag is captured.
- Response: in the cycle after issue, imem_rdata is pushed with its tag unless kill is set. Then inf clears.
- Pop: out_valid && out_ready removes the head. Push and pop in the same cycle keep count unchanged.
- Redirect is taken when redir_valid and any of the following holds. Priority is top to bottom:
  - Jrn: target Read_data_1.
  - Jmp or Jal: target {redir_pc_plus_4[ADDR_W-1:28], jidx, 2'b00}.
  - Branch && Zero: target Add_result.
  - nBranch && !Zero: target Add_result.
- Target bits [1:0] are forced to 0.
- A redirect with no condition met (branch not taken) has no effect.
- Taken redirect at edge E:
  - Queue is emptied.
  - Any in-flight response is killed.
  - fpc <= target.
  - No issue occurs in the redirect cycle.
  - Pop in the same cycle is ignored: redirect wins.
- Reset (reset low at a rising edge), including mid-fetch:
  - fpc <= RESET_PC.
  - count, inf, kill <= 0.
- Reset values of outputs: out_valid 0, imem_en 0, out_instr 0, out_pc_plus_4 0.

## Timing
- imem_en and imem_addr are combinational from registered state. out_* are driven from the queue registers.
- Reset release at edge R: first issue in cycle R+1. Head valid in cycle R+2 with the RESET_PC instruction and out_pc_plus_4 = RESET_PC+4.
- Redirect latency: taken at edge E. out_valid is 0 during cycle E+1. Target instruction is valid in cycle E+2 at the earliest.
- Steady state with out_ready held 1: one instruction per cycle after the 2-cycle fill.
- Queue full with out_ready 0: imem_en stays 0, no words are dropped, and fpc holds.
- fpc increment wraps modulo 2^ADDR_W. The ROM address wraps modulo 2^ROM_AW.

## Configuration
- IFETCH_JAL_LINK_EN defined:
  - Adds output link_valid (1 bit) and link_addr (ADDR_W).
  - On a taken Jal redirect, link_valid pulses high for exactly cycle E+1 and link_addr = the captured redir_pc_plus_4.
  - Both reset to 0.
- Undefined: the link ports do not exist. The link value then comes from the datapath's opcplus4 path.

## Test plan
- Reset release, ROM word i = i, out_ready=1 -> out_valid first high in cycle R+2; instructions 0,1,2,… on consecutive cycles; out_pc_plus_4 = 4,8,12,….
- out_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 entries buffered, imem_en=0 thereafter; release -> words 0..3 then 4 with no gap or duplicate.
- Branch=1, Zero=1, Add_result=0x40, while queue full and a fetch in flight -> flush; next delivered out_pc_plus_4 = 0x44 in cycle E+2; the stale in-flight word is never delivered. Repeat with Zero=0 -> no flush.
- Jrn=1 and Jmp=1 both asserted, Read_data_1=0x103 -> target 0x100 (Jrn priority, low bits cleared).
- Reset low mid-stream with out_valid=1 -> next cycle out_valid=0, imem_en=0; after release, fetch restarts at RESET_PC.
- With IFETCH_JAL_LINK_EN: Jal, redir_pc_plus_4=0x2C -> link_valid=1 for exactly one cycle, link_addr=0x2C.
